// File: rtl/rf_wb_queue.sv
// Register-file write-back queue: merges ALU (A) and load (B) results in program order,
// drains one entry per cycle to the regfile write port and answers decode pending-write queries.
module rf_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_rd,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_rd,
  input  logic [DW-1:0] b_data,
  output logic          wen,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  input  logic [AW-1:0] q_rs1,
  input  logic [AW-1:0] q_rs2,
  output logic          q_hit1,
  output logic [DW-1:0] q_data1,
  output logic          q_hit2,
  output logic [DW-1:0] q_data2
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Handshake: a transfer on port A (B) happens at a posedge where a_valid & a_ready
  // (b_valid & b_ready) are both high; ready depends on the current count only.

  logic [AW-1:0] rd_mem_q   [DEPTH];
  logic [AW-1:0] rd_mem_d   [DEPTH];
  logic [DW-1:0] data_mem_q [DEPTH];
  logic [DW-1:0] data_mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          rdy;
  logic          a_push;
  logic          b_push;
  logic          pop;
  logic [PW-1:0] a_slot;

  // Two free slots are needed so a same-cycle A+B pair always fits.
  assign rdy     = (count_q <= CW'(DEPTH - 2));
  assign a_ready = rdy;
  assign b_ready = rdy;

  // Writes to x0 complete the handshake but never occupy a slot.
  assign b_push = b_valid & rdy & (b_rd != '0);
  assign a_push = a_valid & rdy & (a_rd != '0);
  assign pop    = (count_q != '0);
  assign a_slot = tail_q + PW'(b_push);

  always_comb begin
    rd_mem_d   = rd_mem_q;
    data_mem_d = data_mem_q;
    if (b_push) begin
      rd_mem_d[tail_q]   = b_rd;
      data_mem_d[tail_q] = b_data;
    end
    if (a_push) begin
      rd_mem_d[a_slot]   = a_rd;
      data_mem_d[a_slot] = a_data;
    end
  end

  always_comb begin
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(b_push) + PW'(a_push);
    count_d = count_q + CW'(a_push) + CW'(b_push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      rd_mem_q   <= rd_mem_d;
      data_mem_q <= data_mem_d;
    end
  end

  always_comb begin
    wen   = pop;
    waddr = '0;
    wdata = '0;
    if (pop) begin
      waddr = rd_mem_q[head_q];
      wdata = data_mem_q[head_q];
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    logic [PW-1:0] idx;
    idx     = '0;
    q_hit1  = 1'b0;
    q_data1 = '0;
    q_hit2  = 1'b0;
    q_data2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (CW'(k) < count_q) begin
        if ((q_rs1 != '0) && (rd_mem_q[idx] == q_rs1)) begin
          q_hit1  = 1'b1;
          q_data1 = data_mem_q[idx];
        end
        if ((q_rs2 != '0) && (rd_mem_q[idx] == q_rs2)) begin
          q_hit2  = 1'b1;
          q_data2 = data_mem_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_queue.sv
// Self-checking bench for rf_wb_queue: scenario tasks plus a drain scoreboard fed in issue order.
module tb_rf_wb_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clk;
  logic          rst_n;
  logic          a_valid, b_valid;
  logic          a_ready, b_ready;
  logic [AW-1:0] a_rd, b_rd;
  logic [DW-1:0] a_data, b_data;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [AW-1:0] q_rs1, q_rs2;
  logic          q_hit1, q_hit2;
  logic [DW-1:0] q_data1, q_data2;

  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] mon_w;
  logic [AW+DW-1:0] head_w;
  bit               head_vld;
  bit               mon_en;
  int               cnt_seen;
  int               wr_cnt;
  int               acc_cnt;
  int               pass_cnt;
  int               total_cnt;

  rf_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .a_rd    (a_rd),
    .a_data  (a_data),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .b_rd    (b_rd),
    .b_data  (b_data),
    .wen     (wen),
    .waddr   (waddr),
    .wdata   (wdata),
    .q_rs1   (q_rs1),
    .q_rs2   (q_rs2),
    .q_hit1  (q_hit1),
    .q_data1 (q_data1),
    .q_hit2  (q_hit2),
    .q_data2 (q_data2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard: cnt_seen is the queue occupancy during the current cycle
  always @(negedge clk) begin
    if (mon_en) begin
      cnt_seen = exp_q.size();
      total_cnt++;
      if (a_ready !== (cnt_seen <= DEPTH - 2) || b_ready !== (cnt_seen <= DEPTH - 2))
        $display("FAIL ready: a_ready=%b b_ready=%b expected %b (count %0d)",
                 a_ready, b_ready, (cnt_seen <= DEPTH - 2), cnt_seen);
      else
        pass_cnt++;
      if (wen === 1'b1) wr_cnt++;
      total_cnt++;
      head_vld = (cnt_seen != 0);
      if (cnt_seen != 0) begin
        mon_w  = exp_q.pop_front();
        head_w = mon_w;
        if (wen !== 1'b1 || waddr !== mon_w[AW+DW-1:DW] || wdata !== mon_w[DW-1:0])
          $display("FAIL drain: wen=%b waddr=%0d wdata=%h expected wen=1 waddr=%0d wdata=%h",
                   wen, waddr, wdata, mon_w[AW+DW-1:DW], mon_w[DW-1:0]);
        else
          pass_cnt++;
      end else begin
        if (wen !== 1'b0 || waddr !== '0 || wdata !== '0)
          $display("FAIL idle_port: wen=%b waddr=%0d wdata=%h expected all zero",
                   wen, waddr, wdata);
        else
          pass_cnt++;
      end
    end
  end

  // driver: called at any time, applies inputs just after the next negedge
  task automatic drive(input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                       input logic bv, input logic [AW-1:0] brd, input logic [DW-1:0] bd,
                       output int pushed);
    bit rdy;
    @(negedge clk);
    #1;
    rdy     = (cnt_seen <= DEPTH - 2);
    pushed  = 0;
    a_valid = av;
    a_rd    = ard;
    a_data  = ad;
    b_valid = bv;
    b_rd    = brd;
    b_data  = bd;
    if (bv && rdy && brd != '0) begin
      exp_q.push_back({brd, bd});
      pushed++;
    end
    if (av && rdy && ard != '0) begin
      exp_q.push_back({ard, ad});
      pushed++;
    end
    acc_cnt += pushed;
  endtask

  task automatic idle();
    int p;
    drive(1'b0, '0, '0, 1'b0, '0, '0, p);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    a_rd = '0; b_rd = '0; a_data = '0; b_data = '0;
    q_rs1 = '0; q_rs2 = '0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    mon_en = 1'b1;
    #1;
    total_cnt++;
    if ({wen, waddr, wdata} !== '0)
      $display("FAIL reset_port: wen=%b waddr=%0d wdata=%h expected zeros", wen, waddr, wdata);
    else
      pass_cnt++;
    total_cnt++;
    if ({q_hit1, q_data1, q_hit2, q_data2} !== '0)
      $display("FAIL reset_query: hit1=%b d1=%h hit2=%b d2=%h expected zeros",
               q_hit1, q_data1, q_hit2, q_data2);
    else
      pass_cnt++;
    total_cnt++;
    if ({a_ready, b_ready} !== 2'b11)
      $display("FAIL reset_ready: a_ready=%b b_ready=%b expected 1 1", a_ready, b_ready);
    else
      pass_cnt++;
  endtask

  task automatic test_single();
    int p;
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, p);
    idle();
    total_cnt++;
    if ({wen, waddr, wdata} !== {1'b1, 5'd5, 32'hDEADBEEF})
      $display("FAIL single_write: wen=%b waddr=%0d wdata=%h expected 1 5 deadbeef",
               wen, waddr, wdata);
    else
      pass_cnt++;
    idle();
    total_cnt++;
    if (wen !== 1'b0)
      $display("FAIL single_once: wen=%b expected 0", wen);
    else
      pass_cnt++;
  endtask

  task automatic test_same_cycle();
    int p;
    drive(1'b1, 5'd4, 32'h22, 1'b1, 5'd3, 32'h11, p);
    idle();
    total_cnt++;
    if ({wen, waddr, wdata} !== {1'b1, 5'd3, 32'h11})
      $display("FAIL pair_first: wen=%b waddr=%0d wdata=%h expected 1 3 11", wen, waddr, wdata);
    else
      pass_cnt++;
    idle();
    total_cnt++;
    if ({wen, waddr, wdata} !== {1'b1, 5'd4, 32'h22})
      $display("FAIL pair_second: wen=%b waddr=%0d wdata=%h expected 1 4 22", wen, waddr, wdata);
    else
      pass_cnt++;
    idle();
    total_cnt++;
    if (wen !== 1'b0)
      $display("FAIL pair_end: wen=%b expected 0", wen);
    else
      pass_cnt++;
  endtask

  task automatic test_drop_x0();
    int p;
    drive(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'h1234, p);
    total_cnt++;
    if ({a_ready, b_ready} !== 2'b11)
      $display("FAIL x0_ready: a_ready=%b b_ready=%b expected 1 1", a_ready, b_ready);
    else
      pass_cnt++;
    idle();
    total_cnt++;
    if ({wen, waddr, wdata} !== '0)
      $display("FAIL x0_write: wen=%b waddr=%0d wdata=%h expected zeros", wen, waddr, wdata);
    else
      pass_cnt++;
    idle();
    total_cnt++;
    if (wen !== 1'b0)
      $display("FAIL x0_later: wen=%b expected 0", wen);
    else
      pass_cnt++;
  endtask

  task automatic test_query();
    int p;
    q_rs1 = 5'd7;
    q_rs2 = 5'd0;
    drive(1'b1, 5'd7, 32'h2, 1'b1, 5'd7, 32'h1, p);
    total_cnt++;
    if (q_hit1 !== 1'b0)
      $display("FAIL query_same_cycle: q_hit1=%b expected 0", q_hit1);
    else
      pass_cnt++;
    idle();
    total_cnt++;
    if ({q_hit1, q_data1} !== {1'b1, 32'h2})
      $display("FAIL query_youngest: q_hit1=%b q_data1=%h expected 1 2", q_hit1, q_data1);
    else
      pass_cnt++;
    total_cnt++;
    if ({q_hit2, q_data2} !== {1'b0, 32'h0})
      $display("FAIL query_x0: q_hit2=%b q_data2=%h expected 0 0", q_hit2, q_data2);
    else
      pass_cnt++;
    idle();
    q_rs2 = 5'd7;
    #1;
    total_cnt++;
    if ({q_hit2, q_data2} !== {1'b1, 32'h2})
      $display("FAIL query_head: q_hit2=%b q_data2=%h expected 1 2", q_hit2, q_data2);
    else
      pass_cnt++;
    idle();
    total_cnt++;
    if ({q_hit1, q_data1} !== {1'b0, 32'h0})
      $display("FAIL query_drained: q_hit1=%b q_data1=%h expected 0 0", q_hit1, q_data1);
    else
      pass_cnt++;
    q_rs1 = '0;
    q_rs2 = '0;
  endtask

  task automatic test_fill();
    int p;
    int acc0;
    int wr0;
    bit saw_block;
    acc0 = acc_cnt;
    wr0  = wr_cnt;
    saw_block = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1, 5'($urandom_range(1, 31)), $urandom, p);
      if (a_ready === 1'b0) saw_block = 1'b1;
    end
    idle();
    for (int i = 0; i < 12 && exp_q.size() != 0; i++) idle();
    total_cnt++;
    if (exp_q.size() != 0)
      $display("FAIL fill_timeout: %0d entries still expected after drain budget", exp_q.size());
    else
      pass_cnt++;
    total_cnt++;
    if (saw_block !== 1'b1)
      $display("FAIL fill_backpressure: ready low seen=%b expected 1", saw_block);
    else
      pass_cnt++;
    total_cnt++;
    if ((wr_cnt - wr0) != (acc_cnt - acc0))
      $display("FAIL fill_count: writes=%0d expected %0d", wr_cnt - wr0, acc_cnt - acc0);
    else
      pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int p;
    drive(1'b1, 5'd9, 32'hA9, 1'b1, 5'd8, 32'hB8, p);
    drive(1'b1, 5'd11, 32'hAB, 1'b1, 5'd10, 32'hBA, p);
    idle();
    #1 rst_n = 1'b0;
    q_rs1 = 5'd11;
    #1;
    exp_q.delete();
    cnt_seen = 0;
    head_vld = 1'b0;
    total_cnt++;
    if ({wen, waddr, wdata} !== '0)
      $display("FAIL midreset_port: wen=%b waddr=%0d wdata=%h expected zeros", wen, waddr, wdata);
    else
      pass_cnt++;
    total_cnt++;
    if ({q_hit1, q_data1} !== '0)
      $display("FAIL midreset_query: q_hit1=%b q_data1=%h expected 0 0", q_hit1, q_data1);
    else
      pass_cnt++;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    q_rs1 = '0;
    #1;
    total_cnt++;
    if ({a_ready, b_ready} !== 2'b11)
      $display("FAIL midreset_ready: a_ready=%b b_ready=%b expected 1 1", a_ready, b_ready);
    else
      pass_cnt++;
    repeat (4) idle();
  endtask

  task automatic test_back_to_back();
    int p;
    logic [AW-1:0] rs;
    logic [AW-1:0] e_rd;
    logic          e_hit;
    logic [DW-1:0] e_data;
    logic [AW+DW-1:0] w;
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom, p);
      rs    = 5'($urandom_range(0, 7));
      q_rs1 = rs;
      #1;
      e_hit  = 1'b0;
      e_data = '0;
      if (head_vld) begin
        e_rd = head_w[AW+DW-1:DW];
        if (rs != '0 && e_rd == rs) begin
          e_hit  = 1'b1;
          e_data = head_w[DW-1:0];
        end
      end
      for (int j = 0; j < exp_q.size() - p; j++) begin
        w    = exp_q[j];
        e_rd = w[AW+DW-1:DW];
        if (rs != '0 && e_rd == rs) begin
          e_hit  = 1'b1;
          e_data = w[DW-1:0];
        end
      end
      total_cnt++;
      if ({q_hit1, q_data1} !== {e_hit, e_data})
        $display("FAIL random_query: rs=%0d q_hit1=%b q_data1=%h expected %b %h",
                 rs, q_hit1, q_data1, e_hit, e_data);
      else
        pass_cnt++;
    end
    q_rs1 = '0;
    idle();
    for (int i = 0; i < 12 && exp_q.size() != 0; i++) idle();
    total_cnt++;
    if (exp_q.size() != 0)
      $display("FAIL random_timeout: %0d entries still expected after drain budget", exp_q.size());
    else
      pass_cnt++;
  endtask

  initial begin
    mon_en    = 1'b0;
    head_vld  = 1'b0;
    cnt_seen  = 0;
    wr_cnt    = 0;
    acc_cnt   = 0;
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_single();
    test_same_cycle();
    test_drop_x0();
    test_query();
    test_fill();
    test_reset_mid();
    test_back_to_back();
    repeat (2) idle();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
